// File: rtl/inv_sub_shift_seq.sv
// Iterative AES InvShiftRows + InvSubBytes stage using LANES shared inverse S-box lookups.
// Define INV_SUB_SHIFT_FLUSH_EN to add a synchronous flush input.
module inv_sub_shift_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
`ifdef INV_SUB_SHIFT_FLUSH_EN
  input  logic         flush,
`endif
  output logic         busy
);

  localparam int unsigned NumChunks = (LANES == 0) ? 1 : 16 / LANES;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_shift_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [2047:0] InvSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry b sits at bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSbox[{~b, 3'b111} -: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [127:0]      r_st, w_st_nxt;
  logic [127:0]      w_shifted;
  logic [127:0]      w_win;
  logic [127:0]      w_sub;
  logic [7:0]        w_lane_in  [LANES];
  logic [7:0]        w_lane_out [LANES];
  logic              w_flush;

`ifdef INV_SUB_SHIFT_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Byte k = r + 4c; shifted[r][c] takes in[r][(c - r) mod 4].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned Src = r + 4 * ((c - r + 4) % 4);
      assign w_shifted[127-8*(r+4*c) -: 8] = in_state[127-8*Src -: 8];
    end
  end

  // Current chunk is moved to the top of the window so lane l sees byte cnt*LANES+l.
  assign w_win = r_st << (8 * LANES * r_cnt);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_in[l]  = w_win[127-8*l -: 8];
    assign w_lane_out[l] = inv_sbox(w_lane_in[l]);
  end

  always_comb begin
    w_sub = r_st;
    for (int k = 0; k < 16; k++) begin
      if (k / LANES == int'(r_cnt)) begin
        w_sub[127-8*k -: 8] = w_lane_out[k % LANES];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_st_nxt    = r_st;
    case (r_state)
      StIdle: begin
        if (in_valid && in_ready) begin
          w_st_nxt    = w_shifted;
          w_cnt_nxt   = '0;
          w_state_nxt = StSub;
        end
      end
      StSub: begin
        w_st_nxt = w_sub;
        if (r_cnt == LastCnt) begin
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
        w_st_nxt    = '0;
      end
    endcase
    if (w_flush) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_st_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_st    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_st    <= w_st_nxt;
    end
  end

  assign in_ready  = (r_state == StIdle) && !w_flush;
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign out_state = r_st;

endmodule
